// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// Frame words are {cmd[1:0], payload[7:0]}, shifted MSB first.
package spi_pkg;

    localparam int unsigned SPI_RX_W  = 10;
    localparam int unsigned SPI_TX_W  = 8;
    localparam int unsigned SPI_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first serializer for RAM read data onto MISO.
// Output is registered and idles at 0; a load while busy is never issued.
module spi_tx_serializer #(
    parameter int unsigned TX_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic [TX_W-1:0] i_data,
    output logic            o_miso,
    output logic            o_busy
);

    localparam int unsigned TXC_W = $clog2(TX_W);

    logic [TX_W-1:0]  r_sh;
    logic [TXC_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_miso;

    // The MSB goes out on the load edge itself, so r_sh holds the remaining bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (i_clear) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
        end else if (i_load) begin
            r_sh   <= i_data << 1;
            r_miso <= i_data[TX_W-1];
            r_cnt  <= TXC_W'(TX_W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_miso <= r_sh[TX_W-1];
                r_sh   <= r_sh << 1;
                r_cnt  <= r_cnt - 1'b1;
            end else begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: command decode, rx deserialiser, read-address tracking,
// and the hand-off of RAM read data to the MISO serializer.
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int unsigned RX_W  = SPI_RX_W,
    parameter int unsigned TX_W  = SPI_TX_W,
    parameter int unsigned CNT_W = SPI_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(RX_W - 1);

    spi_state_t       r_state;
    logic [RX_W-2:0]  r_sh;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_frame_done;
    logic             r_rd_addr_done;
    logic             r_tx_taken;
    logic [RX_W-1:0]  r_rx_data;
    logic             r_rx_valid;

    logic             w_tx_load;
    logic             w_tx_busy;
    logic             w_miso;
    logic [RX_W-1:0]  w_word;

    assign w_word = {r_sh, MOSI};

    // Read data is taken once per READ_DATA frame, only after the frame's word is out.
    assign w_tx_load = !SS_n && (r_state == READ_DATA) && r_frame_done && !r_tx_taken &&
                       !w_tx_busy && tx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sh           <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_done <= 1'b0;
            r_tx_taken     <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                r_state      <= IDLE;
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_tx_taken   <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state      <= CHK_CMD;
                        r_bit_cnt    <= '0;
                        r_frame_done <= 1'b0;
                        r_tx_taken   <= 1'b0;
                    end
                    // The command bit steers the path only; the frame repeats it as bit 9.
                    CHK_CMD: begin
                        r_bit_cnt    <= '0;
                        r_frame_done <= 1'b0;
                        r_tx_taken   <= 1'b0;
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_done) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frame_done) begin
                            r_sh <= w_word[RX_W-2:0];
                            if (r_bit_cnt == LastBit) begin
                                r_rx_data    <= w_word;
                                r_rx_valid   <= 1'b1;
                                r_frame_done <= 1'b1;
                                if (r_state == READ_ADD) begin
                                    r_rd_addr_done <= 1'b1;
                                end else if (r_state == READ_DATA) begin
                                    r_rd_addr_done <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_tx_load) begin
                            r_tx_taken <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .TX_W (TX_W)
    ) u_tx (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (SS_n),
        .i_load  (w_tx_load),
        .i_data  (tx_data),
        .o_miso  (w_miso),
        .o_busy  (w_tx_busy)
    );

    assign MISO     = w_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench for spi_slave_fsm: frame-level model with a small RAM, expected rx words
// queued at stimulus time and expected MISO bits keyed by clock cycle.
module tb_spi_slave_fsm;
    import spi_pkg::*;

    localparam int PATH_WR = 0;
    localparam int PATH_RA = 1;
    localparam int PATH_RD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [9:0] exp_rx[$];
    bit         exp_miso[int];

    logic [7:0] mem[256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;
    logic [7:0] m_tx_byte;
    bit         m_rd_done;

    spi_slave_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected words on each rx_valid, compares MISO every cycle.
    always @(negedge clk) begin
        logic [9:0] w;
        bit         want;
        if (rx_valid === 1'b1) begin
            n_checks++;
            if (exp_rx.size() == 0) begin
                n_err++;
                $display("FAIL rx_valid_unexpected: rx_data=%h with no word expected (cycle %0d)",
                         rx_data, cyc);
            end else begin
                w = exp_rx.pop_front();
                if (rx_data !== w) begin
                    n_err++;
                    $display("FAIL rx_data: got %h expected %h (cycle %0d)", rx_data, w, cyc);
                end
            end
        end else if (rx_valid !== 1'b0) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_valid_x: got %b expected 0/1 (cycle %0d)", rx_valid, cyc);
        end
        want = exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0;
        n_checks++;
        if (MISO !== want) begin
            n_err++;
            $display("FAIL miso: got %b expected %b (cycle %0d)", MISO, want, cyc);
        end
    end

    // Frame-level reference: path from the leading bit and the read-address flag, then RAM effect.
    function automatic int model_frame(input logic [9:0] w);
        int path;
        path = !w[9] ? PATH_WR : (m_rd_done ? PATH_RD : PATH_RA);
        exp_rx.push_back(w);
        case (path)
            PATH_WR: begin
                if (w[8]) mem[m_wr_addr] = w[7:0];
                else      m_wr_addr = w[7:0];
            end
            PATH_RA: begin
                m_rd_addr = w[7:0];
                m_rd_done = 1'b1;
            end
            default: begin
                m_tx_byte = mem[m_rd_addr];
                m_rd_done = 1'b0;
            end
        endcase
        return path;
    endfunction

    // Drives SS_n low, the command bit, then nbits frame bits; SS_n is left low.
    task automatic send_frame(input logic [9:0] w, input int nbits, input bit stray,
                              output int path);
        path = -1;
        if (nbits == 10) path = model_frame(w);
        SS_n = 1'b0;
        MOSI = w[9];
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 9; i >= 10 - nbits; i--) begin
            MOSI     = w[i];
            tx_valid = stray ? 1'($urandom) : 1'b0;
            tx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic end_frame(input int gap);
        SS_n = 1'b1;
        MOSI = 1'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // RAM response after a READ_DATA word, plus stray tx_valid pulses that must be ignored.
    task automatic read_tail();
        int m;
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        tx_data  = m_tx_byte;
        tx_valid = 1'b1;
        m = cyc + 1;
        for (int i = 0; i < 8; i++) exp_miso[m + i] = m_tx_byte[7 - i];
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        repeat (3) begin
            @(posedge clk); #1;
        end
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int         path;
        logic [9:0] w;
        int         kind;
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        m_wr_addr = 8'h00;
        m_rd_addr = 8'h00;
        m_tx_byte = 8'h00;
        m_rd_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_miso", 32'(MISO), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rd_addr_done", 32'(dut.r_rd_addr_done), 32'd0);
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));

        // Reset mid-frame after a read-address frame set the flag
        send_frame(10'h2A5, 10, 1'b0, path);
        chk("ra_sets_flag", 32'(dut.r_rd_addr_done), 32'(m_rd_done));
        end_frame(2);
        send_frame(10'h3C3, 5, 1'b0, path);
        #1 rst = 1'b1;
        #1;
        chk("midrst_miso", 32'(MISO), 32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
        chk("midrst_flag", 32'(dut.r_rd_addr_done), 32'd0);
        m_rd_done = 1'b0;
        SS_n = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Write address, write data, read address, read data
        send_frame(10'h0A5, 10, 1'b0, path);
        chk("wr_addr_flag", 32'(dut.r_rd_addr_done), 32'd0);
        end_frame(2);
        send_frame(10'h13C, 10, 1'b1, path);
        chk("wr_data_path", 32'(dut.r_state), 32'(WRITE));
        end_frame(2);
        send_frame(10'h2A5, 10, 1'b0, path);
        chk("rd_addr_path", 32'(dut.r_state), 32'(READ_ADD));
        end_frame(1);
        send_frame(10'h3FF, 10, 1'b0, path);
        chk("rd_data_path", 32'(dut.r_state), 32'(READ_DATA));
        chk("rd_data_flag", 32'(dut.r_rd_addr_done), 32'd0);
        read_tail();
        end_frame(2);

        // Abort a READ_DATA frame after 6 bits; flag survives, next read goes to READ_DATA
        send_frame(10'h2A5, 10, 1'b0, path);
        end_frame(1);
        send_frame(10'h3AA, 6, 1'b0, path);
        end_frame(1);
        chk("abort_state", 32'(dut.r_state), 32'(IDLE));
        chk("abort_flag", 32'(dut.r_rd_addr_done), 32'd1);
        send_frame(10'h355, 10, 1'b0, path);
        chk("post_abort_path", 32'(dut.r_state), 32'(READ_DATA));
        read_tail();
        end_frame(1);

        // Stray tx_valid in IDLE and back-to-back frames with a 1-cycle gap
        tx_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        send_frame(10'h0F0, 10, 1'b1, path);
        end_frame(1);
        send_frame(10'h10F, 10, 1'b1, path);
        end_frame(1);

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 4);
            w    = {2'(kind), 8'($urandom)};
            if (kind == 4) begin
                w = 10'($urandom);
                send_frame(w, $urandom_range(0, 9), 1'b1, path);
                end_frame($urandom_range(1, 3));
                chk("rand_abort_state", 32'(dut.r_state), 32'(IDLE));
                chk("rand_abort_flag", 32'(dut.r_rd_addr_done), 32'(m_rd_done));
            end else begin
                send_frame(w, 10, 1'b1, path);
                chk("rand_flag", 32'(dut.r_rd_addr_done), 32'(m_rd_done));
                if (path == PATH_RD) read_tail();
                else repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                end_frame($urandom_range(1, 3));
            end
        end

        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
